fir_band_sequencer: RTL and testbench
=====================================

// Module: fir_band_sequencer
// PURPOSE
//  Per-sample controller for the equalizer's band FIR engines (coef-ROM MAC, one tap/clk).
//  On each new audio sample, once the sample queue is primed, drives 'sequencing' for a tap sweep.
//  Captures the engines' one-cycle-valid filtered_L/R result into held output registers.
//  Pulses aud_vld to the band-gain/summing stage; flags samples arriving mid-sweep.
// PARAMETERS
//  TAPS        1021  coefficients per sweep (ROM depth used by the band FIR)
//  ROM_LAT     1     coef ROM read latency in clks; sweep length = TAPS+ROM_LAT
//  CAPT_DLY    1     clks after last sequencing-high cycle until filtered_* is sampled (1..3)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  smpl_vld     in   1   1-clk pulse: new L/R sample written to the sample queue
//  queue_full   in   1   queue primed (holds >= TAPS samples); level
//  filtered_L   in   16  band FIR left result, valid only in capture cycle
//  filtered_R   in   16  band FIR right result, valid only in capture cycle
//  sequencing   out  1   to FIR engine and queue read side: sweep active
//  aud_L        out  16  captured left result, held until next capture
//  aud_R        out  16  captured right result, held until next capture
//  aud_vld      out  1   1-clk pulse, same cycle aud_L/R update
//  busy         out  1   high in any state other than IDLE
//  overrun      out  1   sticky: smpl_vld seen while busy (FIR_SEQ_OVERRUN_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sequencing=0, aud_L/R=0, aud_vld=0, busy=0, overrun=0, cnt=0.
//  All outputs registered; no combinational path from inputs to outputs.
//  FSM: IDLE -> SWEEP -> SETTLE -> CAPT -> IDLE.
//   IDLE:   smpl_vld & queue_full -> SWEEP, cnt<=0. smpl_vld & !queue_full: ignored (priming).
//   SWEEP:  sequencing=1; cnt++ each clk; at cnt==TAPS+ROM_LAT-1 -> SETTLE, cnt<=0.
//           sequencing therefore high exactly TAPS+ROM_LAT consecutive clks.
//   SETTLE: sequencing=0; waits CAPT_DLY-1 clks (0 if CAPT_DLY==1) -> CAPT.
//   CAPT:   aud_L<=filtered_L, aud_R<=filtered_R, aud_vld<=1 (one clk) -> IDLE.
//  Latency: smpl_vld edge to aud_vld high = 1 + TAPS + ROM_LAT + CAPT_DLY clks.
//  smpl_vld while busy: sample not re-sequenced, sweep continues undisturbed; overrun set.
//  smpl_vld in the CAPT cycle counts as busy (dropped). Back-to-back: next sweep needs fresh pulse in IDLE.
//  queue_full dropping mid-sweep: ignored; sweep completes.
//  cnt width = $clog2(TAPS+ROM_LAT); terminal compare exact, no wrap beyond terminal.
//  aud_L/R pass filtered_* through unmodified (sign preserved, no saturation here).
// CONFIGURATION
//  FIR_SEQ_OVERRUN_EN defined: overrun sticky-set on smpl_vld while busy; cleared only by rst_n.
//  Not defined: overrun port tied 0, no detection logic; dropped-sample behaviour unchanged.
// STRUCTURE
//  Shared package fir_pkg: FSM state encoding (IDLE/SWEEP/SETTLE/CAPT), TAPS default 1021,
//   ROM_LAT default, audio width 16 - shared with band FIR engines and sample queue.
//  One sub-module: fir_seq_cnt (clear/enable up-counter with terminal-count flag, param width/limit).
//  Single instance serves all band FIRs in lockstep (common sequencing, per-band capture upstream).
// TESTING  (bench uses TAPS=8, ROM_LAT=1, CAPT_DLY=1 unless noted)
//  Reset mid-SWEEP (cnt=4): rst_n low -> sequencing=0 same clk, aud_*=0, busy=0; release -> IDLE.
//  queue_full=0, smpl_vld pulse -> sequencing stays 0, busy 0, no aud_vld.
//  queue_full=1, smpl_vld @T0 -> sequencing high T1..T9 (9 clks), aud_vld @T11, latency 11.
//  Model FIR drives filtered_L=16'h8001, filtered_R=16'h7FFF only in capture clk -> aud_L=8001, aud_R=7FFF held.
//  smpl_vld at cnt=3 and in CAPT cycle -> one aud_vld only; overrun=1 (macro on) / 0 (macro off).
//  CAPT_DLY=3: aud_vld 2 clks later than default; sequencing still exactly 9 clks.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: constants and FSM encoding shared by the band FIR engines, sample queue and sequencer.
package fir_pkg;
  localparam int FIR_TAPS = 1021;
  localparam int FIR_ROM_LAT = 1;
  localparam int AUD_W = 16;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CAPT = 2'd3;
  typedef logic [AUD_W-1:0] aud_t;
endpackage

// File: rtl/fir_band_sequencer_if.sv
// fir_band_sequencer_if: sample/queue inputs, band FIR results and sequencer outputs.
interface fir_band_sequencer_if;
  import fir_pkg::*;
  logic smpl_vld, queue_full, sequencing, aud_vld, busy, overrun;
  aud_t filtered_L, filtered_R, aud_L, aud_R;
  modport master (
    output smpl_vld, queue_full, filtered_L, filtered_R,
    input sequencing, aud_L, aud_R, aud_vld, busy, overrun
  );
  modport slave (
    input smpl_vld, queue_full, filtered_L, filtered_R,
    output sequencing, aud_L, aud_R, aud_vld, busy, overrun
  );
endinterface

// File: rtl/fir_seq_cnt.sv
// fir_seq_cnt: clear/enable up-counter flagging its terminal value; clear wins over enable.
module fir_seq_cnt #(
  parameter int W = 4,
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == W'(LIMIT);
endmodule

// File: rtl/fir_band_sequencer.sv
// fir_band_sequencer: per-sample tap-sweep controller and result capture for the band FIRs.
// Define FIR_SEQ_OVERRUN_EN to enable sticky overrun detection of samples arriving while busy.
module fir_band_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int ROM_LAT = FIR_ROM_LAT,
  parameter int CAPT_DLY = 1
) (
  input logic clk,
  input logic rst_n,
  fir_band_sequencer_if.slave bus
);
  localparam int SWEEP_LEN = TAPS + ROM_LAT;
  localparam int CW = $clog2(SWEEP_LEN);
  localparam logic [1:0] AFTER_SWEEP = CAPT_DLY > 1 ? SETTLE : CAPT;
  localparam logic [1:0] SET_LAST = 2'(CAPT_DLY > 1 ? CAPT_DLY - 2 : 0);
  logic [1:0] state, nxt, scnt;
  logic tc, busy;
  aud_t aud_l, aud_r;
  logic aud_vld;
  fir_seq_cnt #(.W(CW), .LIMIT(SWEEP_LEN - 1)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != SWEEP || tc),
    .en(state == SWEEP),
    .tc(tc)
  );
  assign busy = state != IDLE;
  always_comb
    nxt = state == IDLE   ? (bus.smpl_vld && bus.queue_full ? SWEEP : IDLE) :
          state == SWEEP  ? (tc ? AFTER_SWEEP : SWEEP) :
          state == SETTLE ? (scnt == SET_LAST ? CAPT : SETTLE) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      scnt <= '0;
    end else begin
      state <= nxt;
      scnt <= state == SETTLE ? scnt + 1'b1 : '0;
    end
  // filtered_* is only valid during CAPT, so it is held here until the next capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aud_l <= '0;
      aud_r <= '0;
      aud_vld <= 1'b0;
    end else begin
      aud_vld <= state == CAPT;
      if (state == CAPT) begin
        aud_l <= bus.filtered_L;
        aud_r <= bus.filtered_R;
      end
    end
`ifdef FIR_SEQ_OVERRUN_EN
  logic ovr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovr <= 1'b0;
    else if (bus.smpl_vld && busy) ovr <= 1'b1;
  assign bus.overrun = ovr;
`else
  assign bus.overrun = 1'b0;
`endif
  assign bus.sequencing = state == SWEEP;
  assign bus.busy = busy;
  assign bus.aud_L = aud_l;
  assign bus.aud_R = aud_r;
  assign bus.aud_vld = aud_vld;
endmodule

// File: tb/tb_fir_band_sequencer.sv
// tb_fir_band_sequencer: two sequencers (CAPT_DLY 1 and 3) checked per cycle against a timeline model.
module tb_fir_band_sequencer;
  import fir_pkg::*;
  localparam int TAPS = 8;
  localparam int ROM_LAT = 1;
  logic clk = 0;
  logic rst_n = 0;
  logic smpl_vld = 0;
  logic queue_full = 0;
  logic [15:0] fl[2];
  logic [15:0] fr[2];
  fir_band_sequencer_if b0 ();
  fir_band_sequencer_if b1 ();
  assign b0.smpl_vld = smpl_vld;
  assign b1.smpl_vld = smpl_vld;
  assign b0.queue_full = queue_full;
  assign b1.queue_full = queue_full;
  assign b0.filtered_L = fl[0];
  assign b0.filtered_R = fr[0];
  assign b1.filtered_L = fl[1];
  assign b1.filtered_R = fr[1];
  fir_band_sequencer #(.TAPS(TAPS), .ROM_LAT(ROM_LAT), .CAPT_DLY(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fir_band_sequencer #(.TAPS(TAPS), .ROM_LAT(ROM_LAT), .CAPT_DLY(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int st[2] = '{-1000, -1000};
  int cd[2] = '{1, 3};
  logic [15:0] el[2] = '{16'h0, 16'h0};
  logic [15:0] er[2] = '{16'h0, 16'h0};
  logic eov[2] = '{1'b0, 1'b0};
  bit fix_cap = 0;
  bit meas = 0;
  int p_lat = 0;
  int lat[2] = '{-1, -1};
  int seqn[2] = '{0, 0};
`ifdef FIR_SEQ_OVERRUN_EN
  localparam logic OV_ON = 1'b1;
`else
  localparam logic OV_ON = 1'b0;
`endif

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d] cycle %0d: got %0h expected %0h", tag, d, cyc, obs, exp);
    end
  endtask

  // One clock: check outputs of the current cycle against the model, then drive this cycle's inputs.
  task automatic cycle(input logic sv, input logic qf);
    int c, len, run;
    logic e_seq, e_busy, e_vld;
    logic o_seq[2], o_busy[2], o_vld[2], o_ov[2];
    logic [15:0] o_l[2], o_r[2];
    c = cyc;
    @(negedge clk);
    o_seq = '{b0.sequencing, b1.sequencing};
    o_busy = '{b0.busy, b1.busy};
    o_vld = '{b0.aud_vld, b1.aud_vld};
    o_ov = '{b0.overrun, b1.overrun};
    o_l = '{b0.aud_L, b1.aud_L};
    o_r = '{b0.aud_R, b1.aud_R};
    for (int d = 0; d < 2; d++) begin
      run = TAPS + ROM_LAT;
      len = run + cd[d];
      e_seq = c >= st[d] + 1 && c <= st[d] + run;
      e_busy = c >= st[d] + 1 && c <= st[d] + len;
      e_vld = c == st[d] + len + 1;
      chk("sequencing", d, 32'(o_seq[d]), 32'(e_seq));
      chk("busy", d, 32'(o_busy[d]), 32'(e_busy));
      chk("aud_vld", d, 32'(o_vld[d]), 32'(e_vld));
      chk("aud_L", d, 32'(o_l[d]), 32'(el[d]));
      chk("aud_R", d, 32'(o_r[d]), 32'(er[d]));
      chk("overrun", d, 32'(o_ov[d]), 32'(eov[d]));
      if (meas) begin
        if (o_vld[d] && lat[d] < 0) lat[d] = c - p_lat;
        if (o_seq[d]) seqn[d]++;
      end
      if (rst_n && c == st[d] + len) begin
        fl[d] = fix_cap ? 16'h8001 : 16'($urandom);
        fr[d] = fix_cap ? 16'h7FFF : 16'($urandom);
        el[d] = fl[d];
        er[d] = fr[d];
      end else begin
        fl[d] = 16'($urandom);
        fr[d] = 16'($urandom);
      end
      if (rst_n && sv) begin
        if (e_busy) eov[d] = eov[d] | OV_ON;
        else if (qf) st[d] = c;
      end
    end
    smpl_vld = sv;
    queue_full = qf;
    cyc++;
  endtask

  initial begin
    fl = '{16'h0, 16'h0};
    fr = '{16'h0, 16'h0};
    repeat (3) cycle(0, 0);
    rst_n = 1;
    cycle(1, 0);
    repeat (14) cycle(0, 0);
    fix_cap = 1;
    meas = 1;
    p_lat = cyc;
    cycle(1, 1);
    repeat (20) cycle(0, 1);
    meas = 0;
    fix_cap = 0;
    chk("latency", 0, lat[0], 11);
    chk("latency", 1, lat[1], 13);
    chk("seq_len", 0, seqn[0], 9);
    chk("seq_len", 1, seqn[1], 9);
    chk("aud_L_held", 0, 32'(b0.aud_L), 32'h8001);
    chk("aud_R_held", 1, 32'(b1.aud_R), 32'h7FFF);
    cycle(1, 1);
    repeat (3) cycle(0, 1);
    cycle(1, 1);
    repeat (5) cycle(0, 1);
    cycle(1, 1);
    repeat (16) cycle(0, 1);
    chk("overrun_sticky", 0, 32'(b0.overrun), 32'(OV_ON));
    cycle(1, 1);
    repeat (5) cycle(0, 1);
    rst_n = 0;
    #1;
    chk("rst_sequencing", 0, 32'(b0.sequencing), 0);
    chk("rst_busy", 0, 32'(b0.busy), 0);
    chk("rst_aud_L", 0, 32'(b0.aud_L), 0);
    chk("rst_aud_R", 0, 32'(b0.aud_R), 0);
    chk("rst_overrun", 0, 32'(b0.overrun), 0);
    st = '{-1000, -1000};
    el = '{16'h0, 16'h0};
    er = '{16'h0, 16'h0};
    eov = '{1'b0, 1'b0};
    repeat (2) cycle(0, 1);
    rst_n = 1;
    repeat (3) cycle(0, 1);
    repeat (500) cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    repeat (20) cycle(0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
